instr_sequencer: RTL and testbench

// - Fetch/decode/control stage feeding the 4-bit program counter: latches the 8-bit word at the

---
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control for a 4-bit PC machine.
// Each instruction takes three clocks: FETCH latches the ROM word, DECODE
// evaluates opcode and flags, and EXEC presents the registered strobes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | wait for run or step, then latch rom_data into ir
// DECODE | decode ir and flags, register strobes for the EXEC cycle
// EXEC   | strobes visible for exactly one clock, then back to FETCH
// HALT   | absorbing after HLT; all strobes low, halted high until rst
module instr_sequencer #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic [ADDR_W-1:0]      pc_i,
  input  logic [OP_W+ADDR_W-1:0] rom_data_i,
  input  logic                   zero_flag_i,
  input  logic                   carry_flag_i,
  output logic                   pc_en_o,
  output logic                   jump_o,
  output logic [ADDR_W-1:0]      jump_addr_o,
  output logic [2:0]             alu_op_o,
  output logic                   alu_en_o,
  output logic                   out_load_o,
  output logic [ADDR_W-1:0]      imm_o,
  output logic                   halted_o
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_JNZ = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  state_t                   state_q;
  logic [OP_W+ADDR_W-1:0]   ir_q;
  logic                     pc_en_q;
  logic                     jump_q;
  logic [2:0]               alu_op_q;
  logic                     alu_en_q;
  logic                     out_load_q;
  logic                     halted_q;
  logic [OP_W-1:0]          opcode;

  // The PC only addresses the external ROM; the sequencer never looks at it.
  logic unused_pc;
  assign unused_pc = ^pc_i;

  assign opcode = ir_q[OP_W+ADDR_W-1:ADDR_W];

  // Sequencer FSM; every strobe defaults low so it lasts exactly one EXEC cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_en_q    <= 1'b0;
      jump_q     <= 1'b0;
      alu_op_q   <= 3'd0;
      alu_en_q   <= 1'b0;
      out_load_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_en_q    <= 1'b0;
      jump_q     <= 1'b0;
      alu_en_q   <= 1'b0;
      out_load_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run_i || step_i) begin
            ir_q    <= rom_data_i;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
          pc_en_q <= (opcode != OP_HLT);
          case (opcode)
            OP_LDI: begin alu_op_q <= 3'd5; alu_en_q <= 1'b1; end
            OP_ADD: begin alu_op_q <= 3'd0; alu_en_q <= 1'b1; end
            OP_SUB: begin alu_op_q <= 3'd1; alu_en_q <= 1'b1; end
            OP_AND: begin alu_op_q <= 3'd2; alu_en_q <= 1'b1; end
            OP_OR:  begin alu_op_q <= 3'd3; alu_en_q <= 1'b1; end
            OP_XOR: begin alu_op_q <= 3'd4; alu_en_q <= 1'b1; end
            OP_OUT: out_load_q <= 1'b1;
            OP_JMP: jump_q <= 1'b1;
            OP_JZ:  jump_q <= zero_flag_i;
            OP_JC:  jump_q <= carry_flag_i;
            OP_JNZ: jump_q <= ~zero_flag_i;
            default: ;
          endcase
        end
        S_EXEC: begin
          if (opcode == OP_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign pc_en_o     = pc_en_q;
  assign jump_o      = jump_q;
  assign jump_addr_o = ir_q[ADDR_W-1:0];
  assign imm_o       = ir_q[ADDR_W-1:0];
  assign alu_op_o    = alu_op_q;
  assign alu_en_o    = alu_en_q;
  assign out_load_o  = out_load_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small PC/ROM model around it.
module tb_instr_sequencer;

  logic       clk, rst, run, step, zero_flag, carry_flag;
  logic [3:0] pc;
  logic [7:0] rom_data;
  logic       pc_en, jump, alu_en, out_load, halted;
  logic [3:0] jump_addr, imm;
  logic [2:0] alu_op;

  logic [7:0] rom [16];
  int n_checks = 0;
  int n_pass   = 0;
  int n_pe = 0, n_jmp = 0, n_alu = 0, n_out = 0;
  int s_pe, s_jmp, s_alu, s_out;

  instr_sequencer #(.ADDR_W(4), .OP_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .pc_i(pc),
    .rom_data_i(rom_data), .zero_flag_i(zero_flag), .carry_flag_i(carry_flag),
    .pc_en_o(pc_en), .jump_o(jump), .jump_addr_o(jump_addr), .alu_op_o(alu_op),
    .alu_en_o(alu_en), .out_load_o(out_load), .imm_o(imm), .halted_o(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[pc];

  // External program counter: steps or loads only on pc_en.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 4'd0;
    else if (pc_en) pc <= jump ? jump_addr : pc + 4'd1;
  end

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (pc_en)    n_pe++;
    if (jump)     n_jmp++;
    if (alu_en)   n_alu++;
    if (out_load) n_out++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Pulse reset and release it just after a rising edge.
  task automatic do_reset(input logic run_after);
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = run_after;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
    clear_rom();
    tick(2);
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_jump", jump, 1'b0);
    chk("rst_jump_addr", jump_addr, 4'h0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_out_load", out_load, 1'b0);
    chk("rst_imm", imm, 4'h0);
    chk("rst_halted", halted, 1'b0);

    // Reset in the middle of an ADD's EXEC cycle.
    rom[0] = 8'h21;
    rst = 1'b0; run = 1'b1;
    tick(2);
    chk("add_exec_alu_en", alu_en, 1'b1);
    chk("add_exec_pc_en", pc_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pc_en", pc_en, 1'b0);
    chk("midrst_alu_en", alu_en, 1'b0);
    chk("midrst_imm", imm, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; run = 1'b0;
    s_pe = n_pe;
    tick(4);
    chk("midrst_idle_pc_en_cnt", n_pe - s_pe, 0);
    chk("midrst_halted", halted, 1'b0);
    run = 1'b1;
    tick(2);
    chk("after_rst_fetch_alu_en", alu_en, 1'b1);
    chk("after_rst_fetch_pc_en", pc_en, 1'b1);

    // LDI 3, ADD 2, OUT with run dropping during the OUT decode.
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'h70;
    do_reset(1'b1);
    tick(1);
    chk("ldi_decode_pc_en", pc_en, 1'b0);
    chk("ldi_decode_imm", imm, 4'h3);
    tick(1);
    chk("ldi_alu_en", alu_en, 1'b1);
    chk("ldi_alu_op", alu_op, 3'd5);
    chk("ldi_imm", imm, 4'h3);
    chk("ldi_pc_en", pc_en, 1'b1);
    chk("ldi_jump", jump, 1'b0);
    tick(1);
    chk("ldi_done_pc_en", pc_en, 1'b0);
    chk("ldi_done_alu_en", alu_en, 1'b0);
    chk("ldi_done_pc", pc, 4'h1);
    tick(2);
    chk("add_alu_en", alu_en, 1'b1);
    chk("add_alu_op", alu_op, 3'd0);
    chk("add_imm", imm, 4'h2);
    chk("add_pc_en", pc_en, 1'b1);
    tick(2);
    run = 1'b0;
    tick(1);
    chk("out_load", out_load, 1'b1);
    chk("out_alu_en", alu_en, 1'b0);
    chk("out_pc_en", pc_en, 1'b1);
    chk("out_jump", jump, 1'b0);
    tick(1);
    s_pe = n_pe;
    tick(9);
    chk("run_low_no_pc_en", n_pe - s_pe, 0);
    chk("run_low_pc", pc, 4'h3);

    // Conditional branches: JZ taken, JZ untaken, JC taken, JNZ taken.
    clear_rom();
    rom[0] = 8'h99; rom[9] = 8'h95; rom[10] = 8'hA3; rom[3] = 8'hB7;
    zero_flag = 1'b1; carry_flag = 1'b1;
    do_reset(1'b1);
    tick(2);
    chk("jz_taken_pc_en", pc_en, 1'b1);
    chk("jz_taken_jump", jump, 1'b1);
    chk("jz_taken_addr", jump_addr, 4'h9);
    zero_flag = 1'b0;
    tick(1);
    chk("jz_taken_pc", pc, 4'h9);
    tick(2);
    chk("jz_untaken_pc_en", pc_en, 1'b1);
    chk("jz_untaken_jump", jump, 1'b0);
    chk("jz_untaken_addr", jump_addr, 4'h5);
    tick(1);
    chk("jz_untaken_pc", pc, 4'hA);
    tick(2);
    chk("jc_taken_jump", jump, 1'b1);
    chk("jc_taken_addr", jump_addr, 4'h3);
    tick(1);
    chk("jc_taken_pc", pc, 4'h3);
    tick(2);
    chk("jnz_taken_jump", jump, 1'b1);
    chk("jnz_taken_pc_en", pc_en, 1'b1);
    tick(1);
    chk("jnz_taken_pc", pc, 4'h7);

    // Single-step mode, with a stray step pulse during DECODE.
    clear_rom();
    do_reset(1'b0);
    s_pe = n_pe;
    tick(5);
    chk("step_idle_pc_en_cnt", n_pe - s_pe, 0);
    step = 1'b1; tick(1); step = 1'b0;
    step = 1'b1; tick(1); step = 1'b0;
    chk("step1_exec_pc_en", pc_en, 1'b1);
    tick(8);
    step = 1'b1; tick(1); step = 1'b0;
    tick(9);
    chk("step_pc_en_cnt", n_pe - s_pe, 2);
    chk("step_pc", pc, 4'h2);

    // HLT is absorbing regardless of run/step.
    clear_rom();
    rom[0] = 8'hF0;
    do_reset(1'b1);
    s_pe = n_pe;
    tick(3);
    chk("hlt_halted", halted, 1'b1);
    for (int i = 0; i < 50; i++) begin
      run  = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      tick(1);
      chk("hlt_halted_hold", halted, 1'b1);
    end
    run = 1'b0; step = 1'b0;
    chk("hlt_pc_en_cnt", n_pe - s_pe, 0);
    chk("hlt_pc", pc, 4'h0);

    // JMP F at address F: tight loop at the top of the address space.
    clear_rom();
    rom[0] = 8'h8F; rom[15] = 8'h8F;
    do_reset(1'b1);
    tick(2);
    chk("jmpf_pc_en", pc_en, 1'b1);
    chk("jmpf_jump", jump, 1'b1);
    chk("jmpf_addr", jump_addr, 4'hF);
    tick(1);
    chk("jmpf_pc", pc, 4'hF);
    s_pe = n_pe; s_jmp = n_jmp; s_alu = n_alu; s_out = n_out;
    tick(30);
    chk("loop_pc_en_cnt", n_pe - s_pe, 10);
    chk("loop_jump_cnt", n_jmp - s_jmp, 10);
    chk("loop_alu_en_cnt", n_alu - s_alu, 0);
    chk("loop_out_load_cnt", n_out - s_out, 0);
    chk("loop_pc", pc, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
